// File: rtl/rf_pkg.sv
// Constants shared by the register file wrapper, the write-port decoder and the write arbiter.
package rf_pkg;

   localparam int REG_ADDR_BITS = 5;
   localparam int NR_OF_REGS    = 32;
   localparam int ZERO_REG      = 0;
   localparam int WR_COUNT_BITS = 16;

   // Width of an index into n requesters; a lone requester still needs one bit.
   function automatic int ptr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin search: first set bit of eligible at or above rr_ptr, wrapping past the top.
module rr_priority_picker #(
   parameter int NrOfRequesters = 2,
   parameter int PtrBits        = 1
) (
   input  logic [NrOfRequesters-1:0] eligible,
   input  logic [PtrBits-1:0]        rr_ptr,
   output logic [PtrBits-1:0]        winner,
   output logic                      winner_valid
);

   int idx;

   // Scan from the farthest offset down so the closest candidate to rr_ptr is written last.
   always_comb begin
      winner       = '0;
      winner_valid = 1'b0;
      idx          = 0;
      for (int k = NrOfRequesters - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NrOfRequesters;
         if (eligible[idx]) begin
            winner       = PtrBits'(idx);
            winner_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port: one staged write per cycle,
// driven as a one-hot register enable that never selects x0, with a committed-write counter.
module regfile_write_arbiter
   import rf_pkg::*;
#(
   parameter int NrOfRequesters = 2,
   parameter int NrOfBits       = 32,
   parameter int NrOfRegs       = NR_OF_REGS,
   parameter int AddrBits       = REG_ADDR_BITS
) (
   input  logic                                Clock,
   input  logic                                Reset,
   input  logic                                Tick,
   input  logic [NrOfRequesters-1:0]           req,
   input  logic [NrOfRequesters*AddrBits-1:0]  addr,
   input  logic [NrOfRequesters*NrOfBits-1:0]  data,
   output logic [NrOfRequesters-1:0]           grant,
   output logic [NrOfRegs-1:0]                 wr_sel,
   output logic [NrOfBits-1:0]                 wr_data,
   output logic [WR_COUNT_BITS-1:0]            wr_count
);

   localparam int PtrBits = ptr_bits(NrOfRequesters);

   logic [PtrBits-1:0]        rr_ptr_reg, rr_ptr_next;
   logic                      stage_valid_reg, stage_valid_next;
   logic [AddrBits-1:0]       stage_addr_reg, stage_addr_next;
   logic [NrOfBits-1:0]       stage_data_reg, stage_data_next;
   logic [NrOfRequesters-1:0] grant_q_reg, grant_q_next;
   logic [WR_COUNT_BITS-1:0]  wr_count_reg, wr_count_next;

   logic [NrOfRequesters-1:0] eligible;
   logic [PtrBits-1:0]        winner;
   logic                      winner_valid;

   logic [AddrBits-1:0]       req_addr [NrOfRequesters];
   logic [NrOfBits-1:0]       req_data [NrOfRequesters];

   genvar gi;

   generate
      for (gi = 0; gi < NrOfRequesters; gi++) begin : g_unpack
         assign req_addr[gi] = addr[gi*AddrBits +: AddrBits];
         assign req_data[gi] = data[gi*NrOfBits +: NrOfBits];
      end
   endgenerate

   // The requester being acknowledged this cycle still has req high; masking it
   // stops the same write from being granted a second time.
   assign eligible = req & ~grant_q_reg;

   rr_priority_picker #(
      .NrOfRequesters (NrOfRequesters),
      .PtrBits        (PtrBits)
   ) u_picker (
      .eligible     (eligible),
      .rr_ptr       (rr_ptr_reg),
      .winner       (winner),
      .winner_valid (winner_valid)
   );

   always_comb begin
      rr_ptr_next      = rr_ptr_reg;
      stage_valid_next = 1'b0;
      stage_addr_next  = stage_addr_reg;
      stage_data_next  = stage_data_reg;
      grant_q_next     = '0;
      wr_count_next    = wr_count_reg;

      if (Tick) begin
         // Count only writes the register actually captures, so x0 writes are excluded.
         if (stage_valid_reg && (stage_addr_reg != AddrBits'(ZERO_REG)))
            wr_count_next = wr_count_reg + 1'b1;

         if (winner_valid) begin
            grant_q_next[winner] = 1'b1;
            stage_valid_next     = 1'b1;
            stage_addr_next      = req_addr[winner];
            stage_data_next      = req_data[winner];
            rr_ptr_next          = (winner == PtrBits'(NrOfRequesters - 1)) ? '0 : winner + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rr_ptr_reg      <= '0;
         stage_valid_reg <= 1'b0;
         stage_addr_reg  <= '0;
         stage_data_reg  <= '0;
         grant_q_reg     <= '0;
         wr_count_reg    <= '0;
      end else begin
         rr_ptr_reg      <= rr_ptr_next;
         stage_valid_reg <= stage_valid_next;
         stage_addr_reg  <= stage_addr_next;
         stage_data_reg  <= stage_data_next;
         grant_q_reg     <= grant_q_next;
         wr_count_reg    <= wr_count_next;
      end
   end

   generate
      for (gi = 0; gi < NrOfRegs; gi++) begin : g_sel
         if (gi == ZERO_REG) begin : g_zero
            assign wr_sel[gi] = 1'b0;
         end else begin : g_reg
            assign wr_sel[gi] = stage_valid_reg && (stage_addr_reg == AddrBits'(gi));
         end
      end
   endgenerate

   assign grant    = grant_q_reg;
   assign wr_data  = stage_data_reg;
   assign wr_count = wr_count_reg;

endmodule
